retire_pair_aligner: RTL

RETIRE_PAIR_ALIGNER -- requirements
Module: retire_pair_aligner

---
 rtl/ctr_pkg.sv | 24 ++
 rtl/retire_fifo.sv | 73 +++++++
 rtl/retire_pair_aligner.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ctr_pkg.sv
// ctr_pkg
// Shared types and defaults for the retirement pair aligner.
//   retire_rec_t    : one retired instruction as reported by an execution unit
//   DEFAULT_DEPTH   : per-side record buffer entries (power of two, 2..16)
//   DEFAULT_TIMEOUT : cycles one side may stay pending alone before desync
package ctr_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] reg_rs1;
        logic [31:0] reg_rs2;
        logic [31:0] reg_rd;
        logic [31:0] mem_addr;
        logic [31:0] mem_r_data;
        logic [31:0] mem_w_data;
    } retire_rec_t;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/retire_fifo.sv
// retire_fifo
// Synchronous FIFO of retirement records for one execution side.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset, empties the FIFO
//   push  : write data at the tail (accepted when not full, or when full
//           and a pop happens in the same cycle)
//   data  : record to write
//   pop   : remove the head (ignored when empty)
//   head  : record currently at the head
//   full  : FIFO holds DEPTH records
//   empty : FIFO holds no records
//   count : current occupancy, 0..DEPTH
module retire_fifo
    import ctr_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  retire_rec_t            data,
    input  logic                   pop,
    output retire_rec_t            head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    retire_rec_t   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_pop;
    logic          do_push;

    // The pointers carry one bit more than the address, so equal low bits
    // with differing top bits means full rather than empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // A full FIFO can still take a push when the head leaves in the same
    // cycle, because the freed slot is the one being written.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer state; reset empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Record storage; a write during reset is harmless since the pointers
    // are cleared in the same edge.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

endmodule

// File: rtl/retire_pair_aligner.sv
// retire_pair_aligner
// Lines up the retirement streams of two execution units so that the n-th
// retirement of each side is presented together as one pair.
// Ports:
//   clk_i         : clock
//   rst_i         : synchronous active-high reset
//   ret_valid_1_i : execution 1 retires one instruction this cycle
//   ret_rec_1_i   : execution 1 retirement record
//   ret_valid_2_i : execution 2 retires one instruction this cycle
//   ret_rec_2_i   : execution 2 retirement record
//   retire_o      : one-cycle strobe, a matched pair is on rec_1_o/rec_2_o
//   rec_1_o       : execution 1 record of the pair (held between strobes)
//   rec_2_o       : execution 2 record of the pair (held between strobes)
//   pending_1_o   : execution 1 buffer occupancy
//   pending_2_o   : execution 2 buffer occupancy
//   overflow_o    : sticky, a record was dropped on a full side
//   desync_o      : sticky, one side was pending alone for TIMEOUT cycles
module retire_pair_aligner
    import ctr_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ret_valid_1_i,
    input  retire_rec_t            ret_rec_1_i,
    input  logic                   ret_valid_2_i,
    input  retire_rec_t            ret_rec_2_i,
    output logic                   retire_o,
    output retire_rec_t            rec_1_o,
    output retire_rec_t            rec_2_o,
    output logic [$clog2(DEPTH):0] pending_1_o,
    output logic [$clog2(DEPTH):0] pending_2_o,
    output logic                   overflow_o,
    output logic                   desync_o
);

    localparam int            TW           = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    retire_rec_t            head_1;
    retire_rec_t            head_2;
    logic                   full_1;
    logic                   full_2;
    logic                   empty_1;
    logic                   empty_2;
    logic [$clog2(DEPTH):0] count_1;
    logic [$clog2(DEPTH):0] count_2;
    logic                   pop_pair;
    logic                   one_sided;
    logic                   drop;
    logic [TW-1:0]          desync_cnt;

    // A pair leaves only when both heads exist; at most one pair per cycle.
    assign pop_pair  = !empty_1 && !empty_2;
    assign one_sided = (empty_1 != empty_2);

    // A full side without a pop this cycle has nowhere to put the record.
    assign drop = (ret_valid_1_i && full_1 && !pop_pair) ||
                  (ret_valid_2_i && full_2 && !pop_pair);

    retire_fifo #(.DEPTH(DEPTH)) fifo_1 (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (ret_valid_1_i),
        .data  (ret_rec_1_i),
        .pop   (pop_pair),
        .head  (head_1),
        .full  (full_1),
        .empty (empty_1),
        .count (count_1)
    );

    retire_fifo #(.DEPTH(DEPTH)) fifo_2 (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (ret_valid_2_i),
        .data  (ret_rec_2_i),
        .pop   (pop_pair),
        .head  (head_2),
        .full  (full_2),
        .empty (empty_2),
        .count (count_2)
    );

    // Occupancy comes straight from the FIFO pointer registers, so it
    // already shows the state after the most recent edge.
    assign pending_1_o = count_1;
    assign pending_2_o = count_2;

    // Pair presentation and sticky status. The desync counter only runs
    // while exactly one side holds records, and saturates at TIMEOUT; the
    // flag is raised on the edge where the counter reaches TIMEOUT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retire_o   <= 1'b0;
            rec_1_o    <= '0;
            rec_2_o    <= '0;
            overflow_o <= 1'b0;
            desync_o   <= 1'b0;
            desync_cnt <= '0;
        end else begin
            retire_o <= pop_pair;
            if (pop_pair) begin
                rec_1_o <= head_1;
                rec_2_o <= head_2;
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
            if (one_sided) begin
                if (desync_cnt != TIMEOUT_MAX) begin
                    desync_cnt <= desync_cnt + 1'b1;
                end
                if (desync_cnt >= TIMEOUT_LAST) begin
                    desync_o <= 1'b1;
                end
            end else begin
                desync_cnt <= '0;
            end
        end
    end

endmodule
